// File: rtl/issue_pair_sched_if.sv
// Decoder/pipeline <-> dual-issue scheduler bundle.
// master = ID/EX side driving hazard inputs, slave = scheduler.
interface issue_pair_sched_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [REG_W-1:0] id0_rs1;
  logic [REG_W-1:0] id0_rs2;
  logic [REG_W-1:0] id1_rs1;
  logic [REG_W-1:0] id1_rs2;
  logic [REG_W-1:0] id0_rd;
  logic [REG_W-1:0] id1_rd;
  logic             id0_we;
  logic             id1_we;
  logic             id0_mem;
  logic             id1_mem;
  logic             id0_md;
  logic             id1_md;
  logic             id0_br;
  logic             id_fence;
  logic             mem_idle;
  logic             idex_load;
  logic [REG_W-1:0] idex_load_rd;
  logic             ex_stall;
  logic             br_flush;
  logic             slot0_load;
  logic             slot1_load;
  logic             slot0_kill;
  logic             slot1_kill;
  logic             id_stall;
  logic             split_active;

  modport master (
    output id_valid, id0_rs1, id0_rs2,
    output id1_rs1, id1_rs2, id0_rd, id1_rd,
    output id0_we, id1_we, id0_mem, id1_mem,
    output id0_md, id1_md, id0_br, id_fence,
    output mem_idle, idex_load, idex_load_rd,
    output ex_stall, br_flush,
    input  slot0_load, slot1_load,
    input  slot0_kill, slot1_kill,
    input  id_stall, split_active
  );

  modport slave (
    input  id_valid, id0_rs1, id0_rs2,
    input  id1_rs1, id1_rs2, id0_rd, id1_rd,
    input  id0_we, id1_we, id0_mem, id1_mem,
    input  id0_md, id1_md, id0_br, id_fence,
    input  mem_idle, idex_load, idex_load_rd,
    input  ex_stall, br_flush,
    output slot0_load, slot1_load,
    output slot0_kill, slot1_kill,
    output id_stall, split_active
  );
endinterface

// File: rtl/issue_pair_sched.sv
// Dual-issue pair/split/bubble/flush scheduler for ID/EX slots.
// Define ISSUE_STATS_EN to build the split/load-use/fence counters.
module issue_pair_sched #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  issue_pair_sched_if.slave ip,
  output logic [CNT_W-1:0] stat_split,
  output logic [CNT_W-1:0] stat_lu,
  output logic [CNT_W-1:0] stat_fence
);

  typedef enum logic [1:0] {
    PAIR       = 2'd0,
    SPLIT      = 2'd1,
    FENCE_WAIT = 2'd2
  } state_e;

  localparam logic [REG_W-1:0] R0 = '0;

  state_e state_q;
  state_e state_d;

  logic lrd_nz;
  logic lu_id0;
  logic lu_id1;
  logic raw;
  logic waw;
  logic res;
  logic need_split;
  logic ev_split;
  logic ev_lu;
  logic ev_fence;

  always_comb begin
    lrd_nz = ip.idex_load &
             (ip.idex_load_rd != R0);
    lu_id0 = lrd_nz &
             ((ip.idex_load_rd == ip.id0_rs1) |
              (ip.idex_load_rd == ip.id0_rs2));
    lu_id1 = lrd_nz &
             ((ip.idex_load_rd == ip.id1_rs1) |
              (ip.idex_load_rd == ip.id1_rs2));
    raw = ip.id0_we & (ip.id0_rd != R0) &
          ((ip.id0_rd == ip.id1_rs1) |
           (ip.id0_rd == ip.id1_rs2));
    waw = ip.id0_we & ip.id1_we &
          (ip.id0_rd == ip.id1_rd) &
          (ip.id0_rd != R0);
    res = (ip.id0_mem & ip.id1_mem) |
          (ip.id0_md & ip.id1_md);
    need_split = raw | waw | res | ip.id0_br;
  end

  always_comb begin
    state_d         = state_q;
    ip.slot0_load   = 1'b0;
    ip.slot1_load   = 1'b0;
    ip.slot0_kill   = 1'b0;
    ip.slot1_kill   = 1'b0;
    ip.id_stall     = 1'b0;
    ip.split_active = (state_q == SPLIT);
    ev_split        = 1'b0;
    ev_lu           = 1'b0;
    ev_fence        = 1'b0;
    // ordered: earlier arms override later ones
    priority case (1'b1)
      ip.br_flush: begin
        ip.slot0_kill = 1'b1;
        ip.slot1_kill = 1'b1;
        state_d       = PAIR;
      end
      ip.ex_stall: begin
        ip.id_stall = 1'b1;
      end
      (state_q == FENCE_WAIT): begin
        ip.slot0_kill = 1'b1;
        ip.slot1_kill = 1'b1;
        ip.id_stall   = 1'b1;
        ev_fence      = 1'b1;
        if (ip.mem_idle) state_d = PAIR;
      end
      (state_q == SPLIT) && lu_id1: begin
        ip.slot0_kill = 1'b1;
        ip.slot1_kill = 1'b1;
        ip.id_stall   = 1'b1;
        ev_lu         = 1'b1;
      end
      (state_q == SPLIT): begin
        ip.slot1_load = 1'b1;
        ip.slot0_kill = 1'b1;
        state_d       = PAIR;
      end
      !ip.id_valid: begin
        ip.slot0_kill = 1'b1;
        ip.slot1_kill = 1'b1;
      end
      ip.id_fence && !ip.mem_idle: begin
        ip.slot0_kill = 1'b1;
        ip.slot1_kill = 1'b1;
        ip.id_stall   = 1'b1;
        state_d       = FENCE_WAIT;
      end
      lu_id0 || lu_id1: begin
        ip.slot0_kill = 1'b1;
        ip.slot1_kill = 1'b1;
        ip.id_stall   = 1'b1;
        ev_lu         = 1'b1;
      end
      need_split: begin
        ip.slot0_load = 1'b1;
        ip.slot1_kill = 1'b1;
        ip.id_stall   = 1'b1;
        ev_split      = 1'b1;
        state_d       = SPLIT;
      end
      default: begin
        ip.slot0_load = 1'b1;
        ip.slot1_load = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PAIR;
    else        state_q <= state_d;
  end

`ifdef ISSUE_STATS_EN
  logic [CNT_W-1:0] split_cnt_q, split_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q,    lu_cnt_d;
  logic [CNT_W-1:0] fence_cnt_q, fence_cnt_d;

  // events are already suppressed under ex_stall
  always_comb begin
    split_cnt_d = split_cnt_q + CNT_W'(ev_split);
    lu_cnt_d    = lu_cnt_q    + CNT_W'(ev_lu);
    fence_cnt_d = fence_cnt_q + CNT_W'(ev_fence);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_cnt_q <= '0;
      lu_cnt_q    <= '0;
      fence_cnt_q <= '0;
    end else begin
      split_cnt_q <= split_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      fence_cnt_q <= fence_cnt_d;
    end
  end

  assign stat_split = split_cnt_q;
  assign stat_lu    = lu_cnt_q;
  assign stat_fence = fence_cnt_q;
`else
  logic unused_ev;
  assign unused_ev  = ^{ev_split, ev_lu, ev_fence};
  assign stat_split = '0;
  assign stat_lu    = '0;
  assign stat_fence = '0;
`endif

endmodule

// File: tb/tb_issue_pair_sched.sv
// Directed scoreboard bench for issue_pair_sched.
// Driver queues expectations; negedge monitor pops and compares.
module tb_issue_pair_sched;

`ifdef ISSUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [31:0] stat_split;
  logic [31:0] stat_lu;
  logic [31:0] stat_fence;

  issue_pair_sched_if #(.REG_W(5)) ifc ();

  issue_pair_sched #(
    .REG_W(5),
    .CNT_W(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ip        (ifc),
    .stat_split(stat_split),
    .stat_lu   (stat_lu),
    .stat_fence(stat_fence)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {s0_load, s0_kill, s1_load, s1_kill, id_stall, split_active}
  typedef struct {
    int          step;
    logic [5:0]  ctl;
    logic [31:0] ss;
    logic [31:0] sl;
    logic [31:0] sf;
  } exp_t;

  exp_t q[$];
  int n_run  = 0;
  int n_fail = 0;
  int step   = 0;

  task automatic clr();
    ifc.id_valid     = 1'b0;
    ifc.id0_rs1      = '0;
    ifc.id0_rs2      = '0;
    ifc.id1_rs1      = '0;
    ifc.id1_rs2      = '0;
    ifc.id0_rd       = '0;
    ifc.id1_rd       = '0;
    ifc.id0_we       = 1'b0;
    ifc.id1_we       = 1'b0;
    ifc.id0_mem      = 1'b0;
    ifc.id1_mem      = 1'b0;
    ifc.id0_md       = 1'b0;
    ifc.id1_md       = 1'b0;
    ifc.id0_br       = 1'b0;
    ifc.id_fence     = 1'b0;
    ifc.mem_idle     = 1'b1;
    ifc.idex_load    = 1'b0;
    ifc.idex_load_rd = '0;
    ifc.ex_stall     = 1'b0;
    ifc.br_flush     = 1'b0;
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic ex(input logic [5:0] ctl,
                    input int ss, input int sl,
                    input int sf);
    exp_t e;
    step++;
    e.step = step;
    e.ctl  = ctl;
    e.ss   = STATS ? ss : 0;
    e.sl   = STATS ? sl : 0;
    e.sf   = STATS ? sf : 0;
    q.push_back(e);
  endtask

  task automatic raw_pair();
    ifc.id_valid = 1'b1;
    ifc.id0_we   = 1'b1;
    ifc.id0_rd   = 5'd5;
    ifc.id1_rs1  = 5'd5;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] got;
      e = q.pop_front();
      got = {ifc.slot0_load, ifc.slot0_kill,
             ifc.slot1_load, ifc.slot1_kill,
             ifc.id_stall, ifc.split_active};
      n_run++;
      if (got !== e.ctl) begin
        n_fail++;
        $display("FAIL step%0d ctl got %b want %b",
                 e.step, got, e.ctl);
      end
      n_run++;
      if (stat_split !== e.ss || stat_lu !== e.sl ||
          stat_fence !== e.sf) begin
        n_fail++;
        $display("FAIL step%0d stats got %0d/%0d/%0d want %0d/%0d/%0d",
                 e.step, stat_split, stat_lu, stat_fence,
                 e.ss, e.sl, e.sf);
      end
      n_run++;
      if ((got[5] & got[4]) | (got[3] & got[2])) begin
        n_fail++;
        $display("FAIL step%0d load_kill got %b want no overlap",
                 e.step, got);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr();
    // 1: in reset, idle
    nx(); ex(6'b010100, 0, 0, 0);
    // 2: independent pair
    nx(); rst_n = 1'b1;
    ifc.id_valid = 1'b1;
    ifc.id0_we = 1'b1; ifc.id0_rd = 5'd5;
    ifc.id1_rs1 = 5'd6; ifc.id1_rs2 = 5'd7;
    ifc.id1_we = 1'b1; ifc.id1_rd = 5'd8;
    ex(6'b101000, 0, 0, 0);
    // 3-4: RAW split A then B
    nx(); raw_pair(); ex(6'b100110, 0, 0, 0);
    nx(); raw_pair(); ex(6'b011001, 1, 0, 0);
    // 5-6: load-use on id1_rs2, then issue
    nx(); ifc.id_valid = 1'b1; ifc.id1_rs2 = 5'd3;
    ifc.idex_load = 1'b1; ifc.idex_load_rd = 5'd3;
    ex(6'b010110, 1, 0, 0);
    nx(); ifc.id_valid = 1'b1; ifc.id1_rs2 = 5'd3;
    ex(6'b101000, 1, 1, 0);
    // 7-9: WAW split, B stalled by ex_stall, then B
    for (int i = 0; i < 3; i++) begin
      nx(); ifc.id_valid = 1'b1;
      ifc.id0_we = 1'b1; ifc.id1_we = 1'b1;
      ifc.id0_rd = 5'd9; ifc.id1_rd = 5'd9;
      if (i == 1) ifc.ex_stall = 1'b1;
      case (i)
        0: ex(6'b100110, 1, 1, 0);
        1: ex(6'b000011, 2, 1, 0);
        default: ex(6'b011001, 2, 1, 0);
      endcase
    end
    // 10: WAW to x0 does not split
    nx(); ifc.id_valid = 1'b1;
    ifc.id0_we = 1'b1; ifc.id1_we = 1'b1;
    ex(6'b101000, 2, 1, 0);
    // 11-13: mem conflict split, load-use on id1 in B
    for (int i = 0; i < 3; i++) begin
      nx(); ifc.id_valid = 1'b1;
      ifc.id0_mem = 1'b1; ifc.id1_mem = 1'b1;
      ifc.id1_rs1 = 5'd4;
      if (i == 1) begin
        ifc.idex_load = 1'b1; ifc.idex_load_rd = 5'd4;
      end
      case (i)
        0: ex(6'b100110, 2, 1, 0);
        1: ex(6'b010111, 3, 1, 0);
        default: ex(6'b011001, 3, 2, 0);
      endcase
    end
    // 14: load-use on id0 source
    nx(); ifc.id_valid = 1'b1; ifc.id0_rs1 = 5'd4;
    ifc.idex_load = 1'b1; ifc.idex_load_rd = 5'd4;
    ex(6'b010110, 3, 2, 0);
    // 15: load to x0 never hazards
    nx(); ifc.id_valid = 1'b1; ifc.idex_load = 1'b1;
    ex(6'b101000, 3, 3, 0);
    // 16-17: branch split; flush + ex_stall in B
    nx(); ifc.id_valid = 1'b1; ifc.id0_br = 1'b1;
    ifc.id0_md = 1'b1; ifc.id1_md = 1'b1;
    ex(6'b100110, 3, 3, 0);
    nx(); ifc.id_valid = 1'b1; ifc.id0_br = 1'b1;
    ifc.br_flush = 1'b1; ifc.ex_stall = 1'b1;
    ex(6'b010101, 4, 3, 0);
    // 18: back in PAIR, idle
    nx(); ex(6'b010100, 4, 3, 0);
    // 19: fence with memory already idle
    nx(); ifc.id_valid = 1'b1; ifc.id_fence = 1'b1;
    ex(6'b101000, 4, 3, 0);
    // 20-25: fence wait, mem_idle low 4 cycles
    for (int i = 0; i < 6; i++) begin
      nx(); ifc.id_valid = 1'b1; ifc.id_fence = 1'b1;
      ifc.mem_idle = (i >= 4);
      if (i < 5) ex(6'b010110, 4, 3, (i == 0) ? 0 : i - 1);
      else       ex(6'b101000, 4, 3, 4);
    end
    // 26-28: fence wait frozen by ex_stall
    nx(); ifc.id_valid = 1'b1; ifc.id_fence = 1'b1;
    ifc.mem_idle = 1'b0;
    ex(6'b010110, 4, 3, 4);
    nx(); ifc.id_valid = 1'b1; ifc.id_fence = 1'b1;
    ifc.mem_idle = 1'b0; ifc.ex_stall = 1'b1;
    ex(6'b000010, 4, 3, 4);
    nx(); ifc.id_valid = 1'b1; ifc.id_fence = 1'b1;
    ifc.mem_idle = 1'b0;
    ex(6'b010110, 4, 3, 4);
    // 29: async reset mid-cycle while in FENCE_WAIT
    nx(); ifc.mem_idle = 1'b0; rst_n = 1'b0;
    ex(6'b010100, 0, 0, 0);
    // 30: released, idle
    nx(); rst_n = 1'b1;
    ex(6'b010100, 0, 0, 0);
    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
